// File: rtl/hex_seg_driver.sv
// hex_seg_driver: seven-segment output stage with frame-aligned PWM dimming, blink and lamp test.
// Optional build macro HEX_SEG_DRIVER_FADE_EN: brightness slews one step per frame instead of jumping.
module hex_seg_driver #(
   parameter int unsigned PWM_BITS  = 4,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [6:0]          seg_in,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                blink_en,
   input  logic                lamp_test,
   output logic [6:0]          hex_out,
   output logic                frame_tick
);

   localparam int unsigned      DIV_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BLINK_DIV - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [DIV_W-1:0]    blink_div;
   logic                blink_phase;
   logic [6:0]          seg_sh;
   logic [PWM_BITS-1:0] bright_sh;
   logic                blink_en_sh;

   logic                boundary;
   logic                blink_wrap;
   logic                lit;
   logic                blank;
   logic [PWM_BITS-1:0] bright_next;
   logic [6:0]          hex_next;

   assign boundary   = (pwm_cnt == '1);
   assign blink_wrap = (blink_div == DIV_MAX);

   // All-ones must stay lit on the last PWM slot too, which pwm_cnt < bright_sh alone would miss.
   assign lit   = (bright_sh == '1) || (pwm_cnt < bright_sh);
   assign blank = blink_en_sh && blink_phase;

   always_comb begin
      bright_next = bright_sh;
`ifdef HEX_SEG_DRIVER_FADE_EN
      if (brightness > bright_sh) begin
         bright_next = bright_sh + PWM_BITS'(1);
      end else if (brightness < bright_sh) begin
         bright_next = bright_sh - PWM_BITS'(1);
      end
`else
      bright_next = brightness;
`endif
   end

   always_comb begin
      hex_next = 7'h7F;
      if (lamp_test) begin
         hex_next = 7'h00;
      end else if (lit && !blank) begin
         hex_next = seg_sh;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt     <= '0;
         blink_div   <= '0;
         blink_phase <= 1'b0;
         seg_sh      <= 7'h7F;
         bright_sh   <= '1;
         blink_en_sh <= 1'b0;
         hex_out     <= 7'h7F;
         frame_tick  <= 1'b0;
      end else begin
         pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
         frame_tick <= boundary;
         hex_out    <= hex_next;
         if (boundary) begin
            seg_sh      <= seg_in;
            bright_sh   <= bright_next;
            blink_en_sh <= blink_en;
         end
         if (blink_wrap) begin
            blink_div   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_div <= blink_div + DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hex_seg_driver.sv
// Directed bench for hex_seg_driver with PWM_BITS=4, BLINK_DIV=32.
// n counts rising edges since reset release; pwm_cnt after edge n is n%16, blink_phase is (n/32)%2.
module tb_hex_seg_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] seg_in;
   logic [3:0] brightness;
   logic       blink_en;
   logic       lamp_test;
   logic [6:0] hex_out;
   logic       frame_tick;

   int vectors    = 0;
   int miscompares = 0;
   int n          = 0;

`ifdef HEX_SEG_DRIVER_FADE_EN
   localparam bit FADE = 1'b1;
`else
   localparam bit FADE = 1'b0;
`endif

   hex_seg_driver #(.PWM_BITS(4), .BLINK_DIV(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_in     (seg_in),
      .brightness (brightness),
      .blink_en   (blink_en),
      .lamp_test  (lamp_test),
      .hex_out    (hex_out),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic run_edges(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: n=%0d observed %h expected %h", tag, n, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; seg_in = 7'h40; brightness = 4'hF; blink_en = 1'b0; lamp_test = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_hex", {1'b0, hex_out}, 8'h7F);
         chk("reset_tick", {7'b0, frame_tick}, 8'h00);
      end

      // Boot: first load at edge 16, visible at edge 17; tick every 16 edges.
      reset = 1'b0; n = 0;
      for (int i = 0; i < 48; i++) begin
         tick();
         chk("boot_hex", {1'b0, hex_out}, (n >= 17) ? 8'h7F & 8'h40 : 8'h7F);
         chk("boot_tick", {7'b0, frame_tick}, (n % 16 == 0) ? 8'h01 : 8'h00);
      end

      // Brightness F -> 0: direct load, or 15 single steps with fade.
      brightness = 4'h0;
      if (FADE) begin
         for (int j = 1; j <= 15; j++) begin
            run_edges(16);
            chk("fade_step", {4'b0, dut.bright_sh}, 8'(15 - j));
         end
      end else begin
         run_edges(16);
         chk("direct_load", {4'b0, dut.bright_sh}, 8'h00);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("bright0_hex", {1'b0, hex_out}, 8'h7F);
      end

      // Brightness 4: 4 cycles lit, 12 dark per frame.
      brightness = 4'h4;
      run_edges(FADE ? 64 : 16);
      chk("bright4_sh", {4'b0, dut.bright_sh}, 8'h04);
      for (int i = 0; i < 32; i++) begin
         tick();
         chk("duty4_hex", {1'b0, hex_out}, ((i % 16) < 4) ? 8'h40 : 8'h7F);
      end

      brightness = 4'hF;
      run_edges(FADE ? 176 : 16);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("full_hex", {1'b0, hex_out}, 8'h40);
      end

      // seg_in change at pwm_cnt=5 waits for the boundary.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("seg_old", {1'b0, hex_out}, 8'h40);
      end
      seg_in = 7'h79;
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("seg_hold", {1'b0, hex_out}, 8'h40);
      end
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("seg_new", {1'b0, hex_out}, 8'h79);
      end

      // Blink: blank while pre-edge blink_phase=1, i.e. ((n-1)/32)%2==1.
      blink_en = 1'b1;
      run_edges(16);
      for (int i = 0; i < 96; i++) begin
         tick();
         chk("blink_hex", {1'b0, hex_out}, ((((n - 1) / 32) % 2) == 1) ? 8'h7F : 8'h79);
      end

      // Lamp test for 3 cycles inside a blanked half-period.
      while (!((n % 32) == 6 && ((n / 32) % 2) == 1)) tick();
      chk("pre_lamp", {1'b0, hex_out}, 8'h7F);
      lamp_test = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lamp_on", {1'b0, hex_out}, 8'h00);
      end
      lamp_test = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("lamp_off", {1'b0, hex_out}, 8'h7F);
      end

      // Lamp test across a boundary: shadows still load underneath.
      while ((n % 16) != 14) tick();
      seg_in = 7'h06; blink_en = 1'b0; lamp_test = 1'b1;
      tick();
      chk("lamp_bnd_a", {1'b0, hex_out}, 8'h00);
      tick();
      chk("lamp_bnd_b", {1'b0, hex_out}, 8'h00);
      chk("lamp_bnd_tick", {7'b0, frame_tick}, 8'h01);
      lamp_test = 1'b0;
      tick();
      chk("lamp_bnd_load", {1'b0, hex_out}, 8'h06);

      // Reset mid-frame discards state, then boot timing repeats.
      seg_in = 7'h40;
      while ((n % 16) != 5) tick();
      reset = 1'b1;
      tick();
      chk("midrst_hex", {1'b0, hex_out}, 8'h7F);
      chk("midrst_tick", {7'b0, frame_tick}, 8'h00);
      chk("midrst_seg", {1'b0, dut.seg_sh}, 8'h7F);
      chk("midrst_pwm", {4'b0, dut.pwm_cnt}, 8'h00);
      reset = 1'b0; n = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         chk("reboot_hex", {1'b0, hex_out}, (n >= 17) ? 8'h40 : 8'h7F);
         chk("reboot_tick", {7'b0, frame_tick}, (n == 16) ? 8'h01 : 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
